// File: rtl/seg_pkg.sv
// Shared constants for the multiplexed 7-segment scan driver:
// hex glyph table (bit6..0 = g..a) and the output polarity helper.
package seg_pkg;

  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  localparam logic [7:0] SEG_OFF = 8'h00;

  function automatic logic [7:0] seg_pol(input logic [7:0] v, input bit inv);
    return inv ? ~v : v;
  endfunction

endpackage

// File: rtl/seg_decode.sv
// Combinational hex nibble to 7-segment glyph (a..g, active high), zero latency.
module seg_decode
  import seg_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  assign seg_o = SEG_TABLE[nib_i];

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 7-segment scanner with frame-latched data, leading-zero blanking
// and blink; Sel/Seg are registered one cycle after each scan tick.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int N_DIGITS       = 8,
  parameter int DIV_CNT        = 5000,
  parameter int BLINK_FRAMES   = 125,
  parameter bit SEL_ACTIVE_LOW = 1'b0,
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic                  Clk,
  input  logic                  Reset_N,
  input  logic [4*N_DIGITS-1:0] Disp_Data,
  input  logic [N_DIGITS-1:0]   Dp,
  input  logic [N_DIGITS-1:0]   Blink_Mask,
  input  logic [3:0]            Active_Num,
  input  logic                  Lz_Blank,
  output logic [N_DIGITS-1:0]   Sel,
  output logic [7:0]            Seg,
  output logic                  Frame_Start
);

  localparam int         DIV_W = (DIV_CNT > 1) ? $clog2(DIV_CNT) : 1;
  localparam int         BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [3:0] N_MAX = 4'(N_DIGITS);

  logic [DIV_W-1:0]      div_q, div_d;
  logic [2:0]            idx_q, idx_d;
  logic                  first_q, first_d;
  logic [BLK_W-1:0]      blk_cnt_q, blk_cnt_d;
  logic                  phase_q, phase_d;
  logic [4*N_DIGITS-1:0] data_q, data_d;
  logic [N_DIGITS-1:0]   dp_q, dp_d;
  logic [N_DIGITS-1:0]   mask_q, mask_d;
  logic                  lz_q, lz_d;
  logic [N_DIGITS-1:0]   sel_q, sel_d;
  logic [7:0]            seg_q, seg_d;

  logic                  tick, wrap, frame;
  logic [3:0]            act;
  logic [3:0]            nib;
  logic [6:0]            seg_raw;
  logic [N_DIGITS-1:0]   lz_vec;
  logic                  lz_run;

  assign act         = (Active_Num > N_MAX) ? N_MAX : Active_Num;
  assign tick        = (div_q == DIV_W'(DIV_CNT - 1));
  assign wrap        = (act == 4'd0) || (({1'b0, idx_q} + 4'd1) >= act);
  assign frame       = tick && (wrap || first_q);
  assign Frame_Start = frame;

  always_comb begin
    div_d     = tick ? '0 : div_q + DIV_W'(1);
    idx_d     = idx_q;
    first_d   = first_q;
    blk_cnt_d = blk_cnt_q;
    phase_d   = phase_q;
    data_d    = data_q;
    dp_d      = dp_q;
    mask_d    = mask_q;
    lz_d      = lz_q;
    if (tick) begin
      first_d = 1'b0;
      idx_d   = (wrap || first_q) ? 3'd0 : idx_q + 3'd1;
    end
    // The *_d shadows double as the frame's view, so slot 0 already sees fresh data.
    if (frame) begin
      data_d = Disp_Data;
      dp_d   = Dp;
      mask_d = Blink_Mask;
      lz_d   = Lz_Blank;
      if (blk_cnt_q == BLK_W'(BLINK_FRAMES - 1)) begin
        blk_cnt_d = '0;
        phase_d   = ~phase_q;
      end else begin
        blk_cnt_d = blk_cnt_q + BLK_W'(1);
      end
    end
  end

  // Walk down from the top enabled digit while nibbles stay zero.
  always_comb begin
    lz_vec = '0;
    lz_run = lz_d;
    for (int j = N_DIGITS - 1; j >= 0; j--) begin
      if (4'(j) < act) begin
        lz_run    = lz_run && (data_d[4*j +: 4] == 4'h0);
        lz_vec[j] = lz_run && (j != 0);
      end
    end
  end

  assign nib = data_d[{idx_d, 2'b00} +: 4];

  seg_decode u_seg_decode (
    .nib_i (nib),
    .seg_o (seg_raw)
  );

  always_comb begin
    sel_d = sel_q;
    seg_d = seg_q;
    if (tick) begin
      sel_d = '0;
      seg_d = SEG_OFF;
      if ((act != 4'd0) && !(phase_d && mask_d[idx_d])) begin
        for (int j = 0; j < N_DIGITS; j++) begin
          sel_d[j] = (idx_d == 3'(j));
        end
        seg_d = {dp_d[idx_d], lz_vec[idx_d] ? 7'h00 : seg_raw};
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      div_q     <= '0;
      idx_q     <= '0;
      first_q   <= 1'b1;
      blk_cnt_q <= '0;
      phase_q   <= 1'b0;
      data_q    <= '0;
      dp_q      <= '0;
      mask_q    <= '0;
      lz_q      <= 1'b0;
      sel_q     <= '0;
      seg_q     <= SEG_OFF;
    end else begin
      div_q     <= div_d;
      idx_q     <= idx_d;
      first_q   <= first_d;
      blk_cnt_q <= blk_cnt_d;
      phase_q   <= phase_d;
      data_q    <= data_d;
      dp_q      <= dp_d;
      mask_q    <= mask_d;
      lz_q      <= lz_d;
      sel_q     <= sel_d;
      seg_q     <= seg_d;
    end
  end

  assign Sel = sel_q ^ {N_DIGITS{SEL_ACTIVE_LOW}};
  assign Seg = seg_pol(seg_q, SEG_ACTIVE_LOW);

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench: two scanners (active-high and fully inverted outputs) share stimulus;
// each slot checks Frame_Start at the tick and Sel/Seg one cycle later.
module tb_seg_scan_driver;

  logic        Clk        = 1'b0;
  logic        Reset_N    = 1'b0;
  logic [31:0] Disp_Data  = 32'h0;
  logic [7:0]  Dp         = 8'h00;
  logic [7:0]  Blink_Mask = 8'h00;
  logic [3:0]  Active_Num = 4'd0;
  logic        Lz_Blank   = 1'b0;

  logic [7:0]  sel_a, seg_a, sel_b, seg_b;
  logic        fs_a, fs_b;

  int total = 0;
  int bad   = 0;
  bit skip_sel = 1'b0;

  always #5 Clk = ~Clk;

  seg_scan_driver #(
    .N_DIGITS(8), .DIV_CNT(4), .BLINK_FRAMES(2),
    .SEL_ACTIVE_LOW(1'b0), .SEG_ACTIVE_LOW(1'b0)
  ) u_dut_a (
    .Clk(Clk), .Reset_N(Reset_N), .Disp_Data(Disp_Data), .Dp(Dp),
    .Blink_Mask(Blink_Mask), .Active_Num(Active_Num), .Lz_Blank(Lz_Blank),
    .Sel(sel_a), .Seg(seg_a), .Frame_Start(fs_a)
  );

  seg_scan_driver #(
    .N_DIGITS(8), .DIV_CNT(4), .BLINK_FRAMES(2),
    .SEL_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b1)
  ) u_dut_b (
    .Clk(Clk), .Reset_N(Reset_N), .Disp_Data(Disp_Data), .Dp(Dp),
    .Blink_Mask(Blink_Mask), .Active_Num(Active_Num), .Lz_Blank(Lz_Blank),
    .Sel(sel_b), .Seg(seg_b), .Frame_Start(fs_b)
  );

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance from "display of tick k visible" to "display of tick k+1 visible".
  task automatic slot(input string tag, input logic fs, input logic [7:0] sel,
                      input logic [7:0] seg);
    logic [7:0] nsel;
    logic [7:0] nseg;
    nsel = ~sel;
    nseg = ~seg;
    repeat (3) @(negedge Clk);
    chk({tag, ".fs_a"}, 8'(fs_a), 8'(fs));
    chk({tag, ".fs_b"}, 8'(fs_b), 8'(fs));
    @(negedge Clk);
    if (!skip_sel) begin
      chk({tag, ".sel_a"}, sel_a, sel);
      chk({tag, ".sel_b"}, sel_b, nsel);
    end
    chk({tag, ".seg_a"}, seg_a, seg);
    chk({tag, ".seg_b"}, seg_b, nseg);
  endtask

  // Asynchronous assert part-way through a cycle; release on a falling edge.
  task automatic do_reset(input string tag);
    @(negedge Clk);
    #2 Reset_N = 1'b0;
    #1;
    chk({tag, ".sel_a"}, sel_a, 8'h00);
    chk({tag, ".sel_b"}, sel_b, 8'hFF);
    chk({tag, ".seg_a"}, seg_a, 8'h00);
    chk({tag, ".seg_b"}, seg_b, 8'hFF);
    chk({tag, ".fs_a"}, 8'(fs_a), 8'h00);
    repeat (2) @(negedge Clk);
    chk({tag, ".hold_fs_b"}, 8'(fs_b), 8'h00);
    Reset_N = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Basic three-digit scan
    Active_Num = 4'd3;
    Disp_Data  = 32'h0000_0321;
    do_reset("rst0");
    slot("scan.f1d0", 1'b1, 8'h01, 8'h06);
    slot("scan.f1d1", 1'b0, 8'h02, 8'h5B);
    slot("scan.f1d2", 1'b0, 8'h04, 8'h4F);
    slot("scan.f2d0", 1'b1, 8'h01, 8'h06);
    slot("scan.f2d1", 1'b0, 8'h02, 8'h5B);
    slot("scan.f2d2", 1'b0, 8'h04, 8'h4F);

    // Mid-frame data change is deferred to the next frame
    Active_Num = 4'd2;
    Disp_Data  = 32'h0000_0011;
    slot("shadow.f0d0", 1'b1, 8'h01, 8'h06);
    Disp_Data  = 32'h0000_0022;
    slot("shadow.f0d1", 1'b0, 8'h02, 8'h06);
    slot("shadow.f1d0", 1'b1, 8'h01, 8'h5B);
    slot("shadow.f1d1", 1'b0, 8'h02, 8'h5B);

    // Widen to 8, then shrink to 2 at index 5, then disable
    Active_Num = 4'd8;
    Disp_Data  = 32'h7654_3210;
    slot("shrink.d2", 1'b0, 8'h04, 8'h3F);
    slot("shrink.d3", 1'b0, 8'h08, 8'h3F);
    slot("shrink.d4", 1'b0, 8'h10, 8'h3F);
    slot("shrink.d5", 1'b0, 8'h20, 8'h3F);
    Active_Num = 4'd2;
    slot("shrink.wrap", 1'b1, 8'h01, 8'h3F);
    slot("shrink.d1", 1'b0, 8'h02, 8'h06);
    Active_Num = 4'd0;
    slot("off.t0", 1'b1, 8'h00, 8'h00);
    slot("off.t1", 1'b1, 8'h00, 8'h00);

    // Leading-zero blanking; current frame still uses 0x76543210
    Active_Num = 4'd4;
    Lz_Blank   = 1'b1;
    Disp_Data  = 32'h0000_0005;
    Dp         = 8'h04;
    slot("lz.old1", 1'b0, 8'h02, 8'h06);
    slot("lz.old2", 1'b0, 8'h04, 8'h5B);
    slot("lz.old3", 1'b0, 8'h08, 8'h4F);
    slot("lz.d0", 1'b1, 8'h01, 8'h6D);
    skip_sel = 1'b1;
    slot("lz.d1", 1'b0, 8'h02, 8'h00);
    slot("lz.d2", 1'b0, 8'h04, 8'h80);
    Disp_Data  = 32'h0000_0000;
    slot("lz.d3", 1'b0, 8'h08, 8'h00);
    skip_sel = 1'b0;
    slot("lz.allzero_d0", 1'b1, 8'h01, 8'h3F);

    // Mid-frame reset, then blink on digit 0
    Active_Num = 4'd2;
    Lz_Blank   = 1'b0;
    Dp         = 8'h00;
    Disp_Data  = 32'h0000_0021;
    Blink_Mask = 8'h01;
    do_reset("rst1");
    slot("blink.b1d0", 1'b1, 8'h01, 8'h06);
    slot("blink.b1d1", 1'b0, 8'h02, 8'h5B);
    slot("blink.b2d0", 1'b1, 8'h00, 8'h00);
    slot("blink.b2d1", 1'b0, 8'h02, 8'h5B);
    slot("blink.b3d0", 1'b1, 8'h00, 8'h00);
    slot("blink.b3d1", 1'b0, 8'h02, 8'h5B);
    slot("blink.b4d0", 1'b1, 8'h01, 8'h06);
    slot("blink.b4d1", 1'b0, 8'h02, 8'h5B);
    slot("blink.b5d0", 1'b1, 8'h01, 8'h06);
    slot("blink.b5d1", 1'b0, 8'h02, 8'h5B);
    slot("blink.b6d0", 1'b1, 8'h00, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 Parameter N_DIGITS, default 8: number of multiplexed digits (range 1..8).
REQ-002 Parameter DIV_CNT, default 5000: Clk cycles per digit slot.
REQ-003 Parameter BLINK_FRAMES, default 125: full scan frames per blink half-period.
REQ-004 Parameter SEL_ACTIVE_LOW, default 0: when 1, Sel is inverted at the output.
REQ-005 Parameter SEG_ACTIVE_LOW, default 0: when 1, Seg is inverted at the output.
REQ-006 Clk  input  1  system clock.
REQ-007 Reset_N  input  1  reset; asynchronous, active-low.
REQ-008 Disp_Data  input  4*N_DIGITS  hex nibble per digit; digit i is bits [4i+3:4i].
REQ-009 Dp  input  N_DIGITS  decimal point enable per digit.
REQ-010 Blink_Mask  input  N_DIGITS  per-digit blink enable.
REQ-011 Active_Num  input  4  number of enabled digits, 0..N_DIGITS; values above N_DIGITS are clamped to N_DIGITS.
REQ-012 Lz_Blank  input  1  leading-zero blanking enable.
REQ-013 Sel  output  N_DIGITS  one-hot digit select, registered.
REQ-014 Seg  output  8  segments, bit0=a..bit6=g, bit7=dp, registered.
REQ-015 Frame_Start  output  1  one-cycle pulse at each frame boundary.

Function
REQ-016 Divider counts 0..DIV_CNT-1 and wraps; scan tick is the cycle in which it equals DIV_CNT-1.
REQ-017 On each tick, digit index advances by 1; when index >= Active_Num-1, it wraps to 0.
REQ-018 If Active_Num drops below index+1 mid-frame, the next tick sets index to 0.
REQ-019 Frame boundary is a tick in which index wraps to 0, or the first tick after reset; Frame_Start pulses high in that cycle only.
REQ-020 At each frame boundary, Disp_Data, Dp, Blink_Mask and Lz_Blank are latched into shadow registers; mid-frame input changes do not affect the frame in progress.
REQ-021 Sel and Seg update in the cycle after a tick (latency 1) and are held until the next tick.
REQ-022 Sel has exactly one bit set, bit = index, except when REQ-023 or REQ-025 blanks the digit.
REQ-023 Active_Num==0: index held at 0, Sel all inactive, Seg all inactive, Frame_Start still pulses every tick.
REQ-024 Hex encoding (bit6..0): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
REQ-025 Leading-zero blanking: with shadow Lz_Blank=1, digits from Active_Num-1 downward whose nibble is 0 show segments a..g off, up to the first non-zero digit; digit 0 is never blanked; dp still follows Dp.
REQ-026 Blink phase toggles after every BLINK_FRAMES frame boundaries; while phase=1, digits with shadow Blink_Mask set have Sel inactive and Seg inactive.
REQ-027 Polarity inversions (REQ-004/005) apply after all other logic, including reset and blank values.

Reset
REQ-028 Reset_N low: divider, index, blink counter, blink phase and shadow registers are 0; Frame_Start is 0; Sel and Seg are at inactive level (all 0 before polarity inversion).
REQ-029 Reset asserted mid-frame takes effect immediately; after release, the first tick is a frame boundary.

Structure
REQ-030 Package seg_pkg holds the 16-entry segment encoding constant table and the polarity helper constants.
REQ-031 Sub-module seg_decode: combinational nibble to 7-segment encoder using seg_pkg.

Verification (DIV_CNT=4, BLINK_FRAMES=2, N_DIGITS=8)
REQ-032 Active_Num=3, Disp_Data=0x00000321 -> Sel cycles 01,02,04 every 4 clocks; Seg 06,5B,4F; Frame_Start every 12 clocks.
REQ-033 Active_Num=4, Lz_Blank=1, Disp_Data=0x00000005, Dp=0x04 -> digits 3,2,1 give Seg 00,80,00; digit 0 gives 6D.
REQ-034 Blink_Mask=0x01, Active_Num=2 -> digit 0 Sel is suppressed for 2 frames, then shown for 2 frames, repeating; digit 1 is unaffected.
REQ-035 Disp_Data changed from 0x11 to 0x22 mid-frame -> remainder of frame shows 1s; next frame shows 2s.
REQ-036 Active_Num changed from 8 to 2 while index=5 -> next Sel is 01; Active_Num=0 -> Sel=00, Seg=00.
REQ-037 Reset pulse mid-frame with SEL_ACTIVE_LOW=1 -> Sel=FF immediately; first tick after release asserts Frame_Start and Sel=FE.
